// File: rtl/dac_pkg.sv
// Shared definitions for the SPI DAC controller: FSM state encoding,
// frame width helper and the default write command code.
package dac_pkg;

  // Controller FSM state encoding
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_GAP   = 2'd2;
  localparam logic [1:0] ST_LDAC  = 2'd3;

  // Command code placed in every write frame unless overridden
  localparam logic [3:0] CMD_WRITE_DEFAULT = 4'b0000;

  // Frame length in bits: command, channel address, sample
  function automatic int unsigned frame_width(input int unsigned cmd_w,
                                              input int unsigned addr_w,
                                              input int unsigned data_w);
    return cmd_w + addr_w + data_w;
  endfunction

endpackage

// File: rtl/spi_sck_gen.sv
// SPI mode-0 clock divider: SCK spends CLK_DIV cycles per half-period,
// starting low, and is forced low whenever it is not enabled.
// rise_tick/fall_tick flag the clk edge on which SCK goes high/low.
module spi_sck_gen #(
  parameter int unsigned CLK_DIV = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  output logic sck,
  output logic rise_tick,
  output logic fall_tick
);

  localparam int unsigned DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic [DIV_W-1:0] cnt_q;
  logic             wrap;

  // End of a half-period: SCK toggles on this edge
  assign wrap      = en && (cnt_q == DIV_W'(CLK_DIV - 1));
  assign rise_tick = wrap && !sck;
  assign fall_tick = wrap && sck;

  // Half-period counter and SCK level
  always_ff @(posedge clk) begin
    if (!rst_n || !en) begin
      cnt_q <= '0;
      sck   <= 1'b0;
    end else if (wrap) begin
      cnt_q <= '0;
      sck   <= ~sck;
    end else begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

endmodule

// File: rtl/spi_dac_ctrl.sv
// Multi-channel SPI DAC controller: accepts a sample set, writes one
// {CMD, channel, sample} frame per channel, then strobes LDAC_N.
// Optional MISO readback capture is built when DAC_READBACK_EN is defined.
module spi_dac_ctrl
  import dac_pkg::*;
#(
  parameter int unsigned      DATA_W    = 16,
  parameter int unsigned      CHANNELS  = 2,
  parameter int unsigned      CMD_W     = 4,
  parameter int unsigned      ADDR_W    = 4,
  parameter logic [CMD_W-1:0] CMD_WRITE = CMD_W'(CMD_WRITE_DEFAULT),
  parameter int unsigned      CLK_DIV   = 2,
  parameter int unsigned      CS_GAP    = 2,
  localparam int unsigned     FRAME_W   = frame_width(CMD_W, ADDR_W, DATA_W)
) (
  input  logic                         CLK,
  input  logic                         RST_N,
  input  logic [CHANNELS*DATA_W-1:0]   S_DATA,
  input  logic                         S_VALID,
  output logic                         S_READY,
  output logic                         SCK,
  output logic                         MOSI,
  output logic                         CS_N,
  input  logic                         MISO,
  output logic                         LDAC_N,
  output logic                         BUSY,
  output logic [FRAME_W-1:0]           RDATA,
  output logic [ADDR_W-1:0]            RDATA_CH,
  output logic                         RDATA_VALID
);

  localparam int unsigned BIT_W   = (FRAME_W > 1) ? $clog2(FRAME_W) : 1;
  localparam int unsigned CNT_MAX = (CS_GAP > CLK_DIV) ? CS_GAP : CLK_DIV;
  localparam int unsigned CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

  logic [1:0]                 state_q, state_nxt;
  logic [ADDR_W-1:0]          ch_q;
  logic [BIT_W-1:0]           bit_q;
  logic [CNT_W-1:0]           cnt_q;
  logic [CHANNELS*DATA_W-1:0] data_q;
  logic [FRAME_W-1:0]         tx_q;
  logic                       sck_en, rise_tick, fall_tick, last_bit;

  function automatic logic [FRAME_W-1:0] frame_of(input logic [ADDR_W-1:0] c,
                                                  input logic [DATA_W-1:0] d);
    return {CMD_WRITE, c, d};
  endfunction

  assign sck_en   = (state_q == ST_SHIFT);
  assign last_bit = sck_en && fall_tick && (bit_q == BIT_W'(FRAME_W - 1));
  assign MOSI     = tx_q[FRAME_W-1];

  spi_sck_gen #(.CLK_DIV(CLK_DIV)) u_sck_gen (
    .clk       (CLK),
    .rst_n     (RST_N),
    .en        (sck_en),
    .sck       (SCK),
    .rise_tick (rise_tick),
    .fall_tick (fall_tick)
  );

  // Next-state logic
  always_comb begin
    state_nxt = state_q;
    case (state_q)
      ST_IDLE:  if (S_VALID) state_nxt = ST_SHIFT;
      ST_SHIFT: if (last_bit) state_nxt = ST_GAP;
      ST_GAP: begin
        if (cnt_q == CNT_W'(CS_GAP - 1))
          state_nxt = (ch_q == ADDR_W'(CHANNELS - 1)) ? ST_LDAC : ST_SHIFT;
      end
      ST_LDAC:  if (cnt_q == CNT_W'(CLK_DIV - 1)) state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // State register
  always_ff @(posedge CLK) begin
    if (!RST_N) state_q <= ST_IDLE;
    else        state_q <= state_nxt;
  end

  // Frame datapath: sample latch, channel/bit/phase counters, MOSI shifter.
  // data_q holds only the lanes not yet sent, so the next lane is always at the bottom.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      ch_q   <= '0;
      bit_q  <= '0;
      cnt_q  <= '0;
      data_q <= '0;
      tx_q   <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (S_VALID) begin
            data_q <= S_DATA >> DATA_W;
            ch_q   <= '0;
            bit_q  <= '0;
            tx_q   <= frame_of(ADDR_W'(0), S_DATA[DATA_W-1:0]);
          end
        end
        ST_SHIFT: begin
          cnt_q <= '0;
          if (fall_tick) begin
            tx_q  <= tx_q << 1;
            bit_q <= bit_q + 1'b1;
          end
        end
        ST_GAP: begin
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == CNT_W'(CS_GAP - 1)) begin
            cnt_q <= '0;
            if (state_nxt == ST_SHIFT) begin
              ch_q   <= ch_q + 1'b1;
              bit_q  <= '0;
              tx_q   <= frame_of(ch_q + 1'b1, data_q[DATA_W-1:0]);
              data_q <= data_q >> DATA_W;
            end
          end
        end
        ST_LDAC: cnt_q <= cnt_q + 1'b1;
        default: ;
      endcase
    end
  end

  // Registered strobes derived from the state being entered
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      CS_N    <= 1'b1;
      LDAC_N  <= 1'b1;
      S_READY <= 1'b1;
      BUSY    <= 1'b0;
    end else begin
      CS_N    <= (state_nxt != ST_SHIFT);
      LDAC_N  <= (state_nxt != ST_LDAC);
      S_READY <= (state_nxt == ST_IDLE);
      BUSY    <= (state_nxt != ST_IDLE);
    end
  end

`ifdef DAC_READBACK_EN
  logic [FRAME_W-1:0] rx_q;

  // MISO capture on SCK rising edges; publish the frame as GAP is entered
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      rx_q        <= '0;
      RDATA       <= '0;
      RDATA_CH    <= '0;
      RDATA_VALID <= 1'b0;
    end else begin
      RDATA_VALID <= 1'b0;
      if (rise_tick) rx_q <= {rx_q[FRAME_W-2:0], MISO};
      if (last_bit) begin
        RDATA       <= rx_q;
        RDATA_CH    <= ch_q;
        RDATA_VALID <= 1'b1;
      end
    end
  end
`else
  logic unused_readback;

  assign RDATA           = '0;
  assign RDATA_CH        = '0;
  assign RDATA_VALID     = 1'b0;
  assign unused_readback = ^{MISO, rise_tick};
`endif

endmodule

// File: tb/tb_spi_dac_ctrl.sv
// Directed bench for spi_dac_ctrl: default instance (2 channels, CLK_DIV=2)
// plus a CLK_DIV=1 single-channel instance, each with a simple DAC model.
module tb_spi_dac_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n = 1'b0;

  // Default instance
  logic [31:0] s_data  = '0;
  logic        s_valid = 1'b0;
  logic        s_ready, sck, mosi, cs_n, ldac_n, busy;
  logic        miso = 1'b0;
  logic [23:0] rdata;
  logic [3:0]  rdata_ch;
  logic        rdata_valid;

  // CLK_DIV=1, CHANNELS=1 instance
  logic [15:0] s_data1  = '0;
  logic        s_valid1 = 1'b0;
  logic        s_ready1, sck1, mosi1, cs_n1, ldac_n1, busy1;
  logic        miso1 = 1'b0;
  logic [23:0] rdata1;
  logic [3:0]  rdata_ch1;
  logic        rdata_valid1;

  int pass_cnt = 0;
  int chk_cnt  = 0;
  int cyc      = 0;

  spi_dac_ctrl u0 (
    .CLK(clk), .RST_N(rst_n), .S_DATA(s_data), .S_VALID(s_valid), .S_READY(s_ready),
    .SCK(sck), .MOSI(mosi), .CS_N(cs_n), .MISO(miso), .LDAC_N(ldac_n), .BUSY(busy),
    .RDATA(rdata), .RDATA_CH(rdata_ch), .RDATA_VALID(rdata_valid)
  );

  spi_dac_ctrl #(.CLK_DIV(1), .CHANNELS(1)) u1 (
    .CLK(clk), .RST_N(rst_n), .S_DATA(s_data1), .S_VALID(s_valid1), .S_READY(s_ready1),
    .SCK(sck1), .MOSI(mosi1), .CS_N(cs_n1), .MISO(miso1), .LDAC_N(ldac_n1), .BUSY(busy1),
    .RDATA(rdata1), .RDATA_CH(rdata_ch1), .RDATA_VALID(rdata_valid1)
  );

  always @(posedge clk) cyc <= cyc + 1;

  // DAC model for u0: MOSI frame decode, MISO returns 24'hA5A5A5
  logic [23:0] rx0 = '0, tx0 = '0;
  int          bits0 = 0, ldac_pulses0 = 0;
  logic [23:0] frames0[$];
  int          fbits0[$];

  always @(negedge cs_n) begin rx0 = '0; bits0 = 0; tx0 = 24'hA5A5A5; miso = tx0[23]; end
  always @(posedge sck) if (cs_n === 1'b0) begin rx0 = {rx0[22:0], mosi}; bits0++; end
  always @(negedge sck) if (cs_n === 1'b0) begin tx0 = {tx0[22:0], 1'b0}; miso = tx0[23]; end
  always @(posedge cs_n) begin frames0.push_back(rx0); fbits0.push_back(bits0); end
  always @(negedge ldac_n) ldac_pulses0++;

  // DAC model for u1
  logic [23:0] rx1 = '0;
  int          bits1 = 0, ldac_pulses1 = 0;
  logic [23:0] frames1[$];
  int          fbits1[$];

  always @(negedge cs_n1) begin rx1 = '0; bits1 = 0; end
  always @(posedge sck1) if (cs_n1 === 1'b0) begin rx1 = {rx1[22:0], mosi1}; bits1++; end
  always @(posedge cs_n1) begin frames1.push_back(rx1); fbits1.push_back(bits1); end
  always @(negedge ldac_n1) ldac_pulses1++;

  function automatic logic [31:0] mk_set(input int n);
    logic [15:0] lo;
    lo = 16'(16'h2000 + 2 * n);
    return {16'(lo + 16'd1), lo};
  endfunction

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_cnt++;
    if ({cs_n, sck, mosi, ldac_n} !== 4'b1001) $display("FAIL reset_spi: got %b want 1001", {cs_n, sck, mosi, ldac_n});
    else pass_cnt++;
    chk_cnt++;
    if ({s_ready, busy} !== 2'b10) $display("FAIL reset_hs: got %b want 10", {s_ready, busy});
    else pass_cnt++;
    chk_cnt++;
    if ({rdata_valid, rdata, rdata_ch} !== 29'd0) $display("FAIL reset_rdata: got %h want 0", {rdata_valid, rdata, rdata_ch});
    else pass_cnt++;
    chk_cnt++;
    if ({cs_n1, sck1, ldac_n1, s_ready1, busy1} !== 5'b10110) $display("FAIL reset_u1: got %b want 10110", {cs_n1, sck1, ldac_n1, s_ready1, busy1});
    else pass_cnt++;
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk_cnt++;
    if ({s_ready, busy, cs_n} !== 3'b101) $display("FAIL reset_release: got %b want 101", {s_ready, busy, cs_n});
    else pass_cnt++;
  endtask

  task automatic test_default();
    int cs_rise, l_first, l_last, rdy, p0, rv_n, nz;
    int rv_cyc[4];
    logic [23:0] rv_dat[4];
    logic [3:0]  rv_ch[4];
    logic [3:0]  first;
    cs_rise = -1; l_first = -1; l_last = -1; rdy = -1; rv_n = 0; nz = 0; first = 'x;
    frames0.delete(); fbits0.delete(); p0 = ldac_pulses0;
    @(negedge clk); s_data = {16'hBEEF, 16'h1234}; s_valid = 1'b1;
    @(posedge clk); #1 s_valid = 1'b0;
    for (int t = 1; t <= 400 && rdy < 0; t++) begin
      @(negedge clk);
      if (t == 1) first = {cs_n, mosi, sck, busy};
      if (t > 1 && cs_n && cs_rise < 0) cs_rise = t;
      if (!ldac_n) begin if (l_first < 0) l_first = t; l_last = t; end
      if (rdata_valid) begin
        if (rv_n < 4) begin rv_cyc[rv_n] = t; rv_dat[rv_n] = rdata; rv_ch[rv_n] = rdata_ch; end
        rv_n++;
      end
      if (rdata != 24'd0 || rdata_ch != 4'd0) nz++;
      if (s_ready) rdy = t;
    end
    chk_cnt++;
    if (first !== 4'b0001) $display("FAIL dflt_cycle1: got %b want 0001 (cs_n,mosi,sck,busy)", first);
    else pass_cnt++;
    chk_cnt++;
    if (cs_rise !== 97) $display("FAIL dflt_cs_rise: got %0d want 97", cs_rise);
    else pass_cnt++;
    chk_cnt++;
    if (l_first !== 197 || l_last !== 198 || ldac_pulses0 - p0 !== 1)
      $display("FAIL dflt_ldac: got %0d..%0d pulses %0d want 197..198 pulses 1", l_first, l_last, ldac_pulses0 - p0);
    else pass_cnt++;
    chk_cnt++;
    if (rdy !== 199) $display("FAIL dflt_ready: got %0d want 199", rdy);
    else pass_cnt++;
    chk_cnt++;
    if (frames0.size() !== 2 || frames0[0] !== 24'h001234 || fbits0[0] !== 24)
      $display("FAIL dflt_frame0: got n=%0d %h/%0d want 001234/24", frames0.size(),
               frames0.size() > 0 ? frames0[0] : 24'hx, fbits0.size() > 0 ? fbits0[0] : -1);
    else pass_cnt++;
    chk_cnt++;
    if (frames0.size() !== 2 || frames0[1] !== 24'h01BEEF || fbits0[1] !== 24)
      $display("FAIL dflt_frame1: got n=%0d %h want 01beef/24", frames0.size(),
               frames0.size() > 1 ? frames0[1] : 24'hx);
    else pass_cnt++;
`ifdef DAC_READBACK_EN
    chk_cnt++;
    if (rv_n !== 2) $display("FAIL rb_count: got %0d want 2", rv_n);
    else pass_cnt++;
    chk_cnt++;
    if (rv_cyc[0] !== 97 || rv_cyc[1] !== 195) $display("FAIL rb_cycle: got %0d,%0d want 97,195", rv_cyc[0], rv_cyc[1]);
    else pass_cnt++;
    chk_cnt++;
    if (rv_dat[0] !== 24'hA5A5A5 || rv_dat[1] !== 24'hA5A5A5) $display("FAIL rb_data: got %h,%h want a5a5a5", rv_dat[0], rv_dat[1]);
    else pass_cnt++;
    chk_cnt++;
    if (rv_ch[0] !== 4'd0 || rv_ch[1] !== 4'd1) $display("FAIL rb_ch: got %0d,%0d want 0,1", rv_ch[0], rv_ch[1]);
    else pass_cnt++;
`else
    chk_cnt++;
    if (rv_n !== 0 || nz !== 0) $display("FAIL rb_absent: got valid=%0d nonzero=%0d want 0,0", rv_n, nz);
    else pass_cnt++;
`endif
  endtask

  task automatic test_clkdiv1();
    int cs_rise, l_first, l_last, rdy, sck_err;
    cs_rise = -1; l_first = -1; l_last = -1; rdy = -1; sck_err = 0;
    frames1.delete(); fbits1.delete();
    @(negedge clk); s_data1 = 16'hFFFF; s_valid1 = 1'b1;
    @(posedge clk); #1 s_valid1 = 1'b0;
    for (int t = 1; t <= 200 && rdy < 0; t++) begin
      @(negedge clk);
      if (t <= 48 && sck1 !== ((t % 2) == 0)) sck_err++;
      if (t > 1 && cs_n1 && cs_rise < 0) cs_rise = t;
      if (!ldac_n1) begin if (l_first < 0) l_first = t; l_last = t; end
      if (s_ready1) rdy = t;
    end
    chk_cnt++;
    if (sck_err !== 0) $display("FAIL div1_sck: got %0d bad cycles want 0", sck_err);
    else pass_cnt++;
    chk_cnt++;
    if (frames1.size() !== 1 || frames1[0] !== 24'h00FFFF || fbits1[0] !== 24)
      $display("FAIL div1_frame: got n=%0d %h/%0d want 00ffff/24", frames1.size(),
               frames1.size() > 0 ? frames1[0] : 24'hx, fbits1.size() > 0 ? fbits1[0] : -1);
    else pass_cnt++;
    chk_cnt++;
    if (cs_rise !== 49) $display("FAIL div1_cs_rise: got %0d want 49", cs_rise);
    else pass_cnt++;
    chk_cnt++;
    if (l_first !== 51 || l_last !== 51 || rdy !== 52)
      $display("FAIL div1_ldac: got ldac %0d..%0d ready %0d want 51..51 ready 52", l_first, l_last, rdy);
    else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    int hs[3];
    int n, bad, rdy;
    logic [31:0] d;
    frames0.delete(); fbits0.delete();
    n = 0; bad = 0; rdy = -1;
    @(negedge clk); s_data = mk_set(0); s_valid = 1'b1;
    for (int t = 0; t < 2000 && n < 3; t++) begin
      if (s_ready) begin
        hs[n] = cyc; n++;
        @(posedge clk); #1;
        if (n == 3) s_valid = 1'b0;
        else s_data = mk_set(n);
      end
      @(negedge clk);
    end
    s_valid = 1'b0;
    for (int t = 0; t < 400 && rdy < 0; t++) begin
      @(negedge clk);
      if (s_ready) rdy = t;
    end
    chk_cnt++;
    if (n !== 3 || rdy < 0) $display("FAIL b2b_done: got %0d sets ready=%0d want 3 sets", n, rdy);
    else pass_cnt++;
    chk_cnt++;
    if (hs[1] - hs[0] !== 199 || hs[2] - hs[1] !== 199)
      $display("FAIL b2b_interval: got %0d,%0d want 199,199", hs[1] - hs[0], hs[2] - hs[1]);
    else pass_cnt++;
    for (int i = 0; i < 6; i++) begin
      d = mk_set(i / 2);
      if (frames0.size() > i) begin
        if (frames0[i] !== ((i % 2) == 0 ? {8'h00, d[15:0]} : {8'h01, d[31:16]})) bad++;
      end
    end
    chk_cnt++;
    if (frames0.size() !== 6 || bad !== 0) $display("FAIL b2b_frames: got n=%0d bad=%0d want 6,0", frames0.size(), bad);
    else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    int p0, rdy;
    frames0.delete(); fbits0.delete();
    p0 = ldac_pulses0; rdy = -1;
    @(negedge clk); s_data = {16'hCAFE, 16'h5555}; s_valid = 1'b1;
    @(posedge clk); #1 s_valid = 1'b0;
    repeat (130) @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    chk_cnt++;
    if ({cs_n, sck, s_ready, busy, ldac_n} !== 5'b10101)
      $display("FAIL rstmid_state: got %b want 10101 (cs_n,sck,ready,busy,ldac_n)", {cs_n, sck, s_ready, busy, ldac_n});
    else pass_cnt++;
    repeat (300) @(negedge clk);
    chk_cnt++;
    if (ldac_pulses0 !== p0 || s_ready !== 1'b1) $display("FAIL rstmid_no_ldac: got pulses %0d ready %b want 0,1", ldac_pulses0 - p0, s_ready);
    else pass_cnt++;
    chk_cnt++;
    if (frames0.size() !== 2 || frames0[0] !== 24'h005555 || fbits0[0] !== 24 || fbits0[1] >= 24)
      $display("FAIL rstmid_abort: got n=%0d %h bits1=%0d want 005555 then short frame", frames0.size(),
               frames0.size() > 0 ? frames0[0] : 24'hx, fbits0.size() > 1 ? fbits0[1] : -1);
    else pass_cnt++;
    frames0.delete(); fbits0.delete();
    @(negedge clk); s_data = {16'h0A0B, 16'h0C0D}; s_valid = 1'b1;
    @(posedge clk); #1 s_valid = 1'b0;
    for (int t = 1; t <= 400 && rdy < 0; t++) begin
      @(negedge clk);
      if (s_ready) rdy = t;
    end
    chk_cnt++;
    if (rdy !== 199 || frames0.size() !== 2 || frames0[0] !== 24'h000C0D || frames0[1] !== 24'h010A0B)
      $display("FAIL rstmid_recover: got ready %0d n=%0d want 199 with 000c0d,010a0b", rdy, frames0.size());
    else pass_cnt++;
  endtask

  task automatic test_busy_ignore();
    int p0, rdy, rdy_err;
    frames0.delete(); fbits0.delete();
    p0 = ldac_pulses0; rdy = -1; rdy_err = 0;
    @(negedge clk); s_data = {16'h2222, 16'h1111}; s_valid = 1'b1;
    @(posedge clk); #1 s_valid = 1'b0;
    for (int t = 1; t <= 400 && rdy < 0; t++) begin
      @(negedge clk);
      if (s_valid && s_ready) rdy_err++;
      if (s_ready) rdy = t;
      if (t == 40 || t == 120) begin s_data = 32'hDEADDEAD; s_valid = 1'b1; end
      if (t == 44 || t == 124) s_valid = 1'b0;
    end
    s_valid = 1'b0;
    chk_cnt++;
    if (rdy_err !== 0) $display("FAIL busy_ready: got %0d ready cycles while busy want 0", rdy_err);
    else pass_cnt++;
    chk_cnt++;
    if (rdy !== 199 || ldac_pulses0 - p0 !== 1) $display("FAIL busy_timing: got ready %0d pulses %0d want 199,1", rdy, ldac_pulses0 - p0);
    else pass_cnt++;
    chk_cnt++;
    if (frames0.size() !== 2 || frames0[0] !== 24'h001111 || frames0[1] !== 24'h012222)
      $display("FAIL busy_frames: got n=%0d want 001111,012222", frames0.size());
    else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_default();
    test_clkdiv1();
    test_back_to_back();
    test_reset_mid();
    test_busy_ignore();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d so far", pass_cnt, chk_cnt);
    $fatal(1, "watchdog");
  end

endmodule
